// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection controller blocks.
//   SEC_W                : width of a seconds value.
//   LFOSC_HZ             : low-frequency oscillator rate in cycles per second.
//   phase_timer_state_t  : phase_timer FSM states.
// -----------------------------------------------------------------------------
package traffic_pkg;

  localparam int SEC_W    = 16;
  localparam int LFOSC_HZ = 10000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } phase_timer_state_t;

endpackage : traffic_pkg

// File: rtl/phase_timer_if.sv
// -----------------------------------------------------------------------------
// phase_timer_if
// Request/response bundle between the traffic FSM (master) and phase_timer
// (slave).
//   enable           : count enable (master -> slave)
//   start            : one-cycle request pulse (master -> slave)
//   seconds_to_count : interval length, sampled with start (master -> slave)
//   busy             : interval being counted (slave -> master)
//   finished         : one-cycle expiry pulse (slave -> master)
//   remaining        : whole seconds left, only with PHASE_TIMER_REMAIN_EN
// Configuration macro: PHASE_TIMER_REMAIN_EN adds the remaining signal.
// -----------------------------------------------------------------------------
interface phase_timer_if #(
  parameter int SEC_W = traffic_pkg::SEC_W
) ();

  logic             enable;
  logic             start;
  logic [SEC_W-1:0] seconds_to_count;
  logic             busy;
  logic             finished;
`ifdef PHASE_TIMER_REMAIN_EN
  logic [SEC_W-1:0] remaining;

  modport master (
    output enable, start, seconds_to_count,
    input  busy, finished, remaining
  );

  modport slave (
    input  enable, start, seconds_to_count,
    output busy, finished, remaining
  );
`else
  modport master (
    output enable, start, seconds_to_count,
    input  busy, finished
  );

  modport slave (
    input  enable, start, seconds_to_count,
    output busy, finished
  );
`endif

endinterface : phase_timer_if

// File: rtl/sec_tick_gen.sv
// -----------------------------------------------------------------------------
// sec_tick_gen
// Prescaler turning CLK_HZ enabled clock cycles into one seconds tick.
//   clk    : oscillator clock
//   reset  : asynchronous, active-high reset
//   clear  : synchronous clear of the prescaler (interval load)
//   enable : advance the prescaler this cycle
//   tick   : high in the enabled cycle where the prescaler wraps to 0
// -----------------------------------------------------------------------------
module sec_tick_gen #(
  parameter int CLK_HZ = traffic_pkg::LFOSC_HZ
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            PRESC_W   = $clog2(CLK_HZ);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else leaves it unassigned and infers a latch.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    // A load restarts the second boundary; it must not also emit a tick.
    if (clear) begin
      presc_d = '0;
    end else if (enable) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule : sec_tick_gen

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Seconds-resolution phase timer: a start pulse loads an interval of N
// seconds, the block counts it on the LFOSC clock and answers with a
// one-cycle finished pulse. A start while counting restarts the interval and
// the aborted one never reports.
//   clk   : LFOSC clock
//   reset : asynchronous, active-high reset
//   bus   : phase_timer_if slave modport (enable, start, seconds_to_count in;
//           busy, finished and optional remaining out)
// Configuration macro: PHASE_TIMER_REMAIN_EN drives bus.remaining with the
// seconds left while counting (0 otherwise).
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int CLK_HZ = traffic_pkg::LFOSC_HZ,
  parameter int SEC_W  = traffic_pkg::SEC_W
) (
  input  logic          clk,
  input  logic          reset,
  phase_timer_if.slave  bus
);

  import traffic_pkg::*;

  phase_timer_state_t state_q, state_d;
  logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic               tick;
  logic               presc_en;
  logic               presc_clear;

  // The prescaler only runs while counting; enable is ignored elsewhere.
  // Any start restarts the second boundary, whatever state it lands in.
  assign presc_en    = bus.enable && (state_q == COUNT);
  assign presc_clear = bus.start;

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (presc_clear),
    .enable (presc_en),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;

    if (bus.start) begin
      // Accepted in every state; a zero-length interval reports immediately.
      sec_cnt_d = bus.seconds_to_count;
      state_d   = (bus.seconds_to_count == '0) ? DONE : COUNT;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        COUNT: begin
          if (tick) begin
            // sec_cnt_q is at least 1 in COUNT, so this never underflows.
            sec_cnt_d = sec_cnt_q - SEC_W'(1);
            if (sec_cnt_q == SEC_W'(1)) begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sec_cnt_q <= sec_cnt_d;
    end
  end

  assign bus.busy     = (state_q == COUNT);
  assign bus.finished = (state_q == DONE);

`ifdef PHASE_TIMER_REMAIN_EN
  assign bus.remaining = (state_q == COUNT) ? sec_cnt_q : '0;
`endif

endmodule : phase_timer

// File: tb/tb_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_phase_timer
// Directed bench for phase_timer with CLK_HZ=10. Cycle c of a scenario is the
// clock period following the c-th rising edge after the start pulse, which is
// driven in cycle 0. Outputs are sampled 1 time unit after each rising edge.
// Covers PHASE_TIMER_REMAIN_EN when the macro is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_phase_timer;

  localparam int CLK_HZ = 10;
  localparam int SEC_W  = 16;

  logic clk;
  logic reset;
  int   assertions;
  int   failures;
  int   cyc;

  phase_timer_if #(.SEC_W(SEC_W)) bus ();

  phase_timer #(
    .CLK_HZ (CLK_HZ),
    .SEC_W  (SEC_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset                = 1'b1;
    bus.start            = 1'b0;
    bus.enable           = 1'b1;
    bus.seconds_to_count = '0;
    @(posedge clk);
    #1;
    assertions++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    assertions++;
    if (bus.finished !== 1'b0) begin
      failures++;
      $display("FAIL reset_finished got=%b exp=0", bus.finished);
    end
`ifdef PHASE_TIMER_REMAIN_EN
    assertions++;
    if (bus.remaining !== 16'd0) begin
      failures++;
      $display("FAIL reset_remaining got=%0d exp=0", bus.remaining);
    end
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
  endtask

  // N=3, enable high: busy 1..30, finished 31; input changes after the start
  // must not affect the interval.
  task automatic test_basic();
    logic exp_b, exp_f;
    int   exp_r;
    cyc = 0;
    bus.seconds_to_count = 16'd3;
    bus.start            = 1'b1;
    bus.enable           = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      bus.start            = 1'b0;
      bus.seconds_to_count = 16'd9;
      exp_b = (cyc >= 1) && (cyc <= 30);
      exp_f = (cyc == 31);
      assertions++;
      if (bus.busy !== exp_b) begin
        failures++;
        $display("FAIL basic_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_b);
      end
      assertions++;
      if (bus.finished !== exp_f) begin
        failures++;
        $display("FAIL basic_finished cyc=%0d got=%b exp=%b", cyc, bus.finished, exp_f);
      end
`ifdef PHASE_TIMER_REMAIN_EN
      if (cyc <= 10)      exp_r = 3;
      else if (cyc <= 20) exp_r = 2;
      else if (cyc <= 30) exp_r = 1;
      else                exp_r = 0;
      assertions++;
      if (bus.remaining !== 16'(exp_r)) begin
        failures++;
        $display("FAIL basic_remaining cyc=%0d got=%0d exp=%0d", cyc, bus.remaining, exp_r);
      end
`endif
    end
  endtask

  // N=0 with enable low: finished in cycle 1 only, busy never rises.
  task automatic test_zero();
    logic exp_f;
    cyc = 0;
    bus.seconds_to_count = 16'd0;
    bus.start            = 1'b1;
    bus.enable           = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      bus.start = 1'b0;
      exp_f = (cyc == 1);
      assertions++;
      if (bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL zero_busy cyc=%0d got=%b exp=0", cyc, bus.busy);
      end
      assertions++;
      if (bus.finished !== exp_f) begin
        failures++;
        $display("FAIL zero_finished cyc=%0d got=%b exp=%b", cyc, bus.finished, exp_f);
      end
    end
    bus.enable = 1'b1;
  endtask

  // N=2, enable low in cycles 8..12: busy 1..25, finished 26.
  task automatic test_enable();
    logic exp_b, exp_f;
    cyc = 0;
    bus.seconds_to_count = 16'd2;
    bus.start            = 1'b1;
    bus.enable           = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      bus.start  = 1'b0;
      bus.enable = !((cyc >= 8) && (cyc <= 12));
      exp_b = (cyc >= 1) && (cyc <= 25);
      exp_f = (cyc == 26);
      assertions++;
      if (bus.busy !== exp_b) begin
        failures++;
        $display("FAIL enable_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_b);
      end
      assertions++;
      if (bus.finished !== exp_f) begin
        failures++;
        $display("FAIL enable_finished cyc=%0d got=%b exp=%b", cyc, bus.finished, exp_f);
      end
    end
    bus.enable = 1'b1;
  endtask

  // N=5, restarted with N=1 in cycle 20: single finished in cycle 31.
  task automatic test_restart();
    logic exp_b, exp_f;
    int   exp_r;
    cyc = 0;
    bus.seconds_to_count = 16'd5;
    bus.start            = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      bus.start = 1'b0;
      if (cyc == 20) begin
        bus.start            = 1'b1;
        bus.seconds_to_count = 16'd1;
      end
      exp_b = (cyc >= 1) && (cyc <= 30);
      exp_f = (cyc == 31);
      assertions++;
      if (bus.busy !== exp_b) begin
        failures++;
        $display("FAIL restart_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_b);
      end
      assertions++;
      if (bus.finished !== exp_f) begin
        failures++;
        $display("FAIL restart_finished cyc=%0d got=%b exp=%b", cyc, bus.finished, exp_f);
      end
`ifdef PHASE_TIMER_REMAIN_EN
      if (cyc <= 10)      exp_r = 5;
      else if (cyc <= 20) exp_r = 4;
      else if (cyc <= 30) exp_r = 1;
      else                exp_r = 0;
      assertions++;
      if (bus.remaining !== 16'(exp_r)) begin
        failures++;
        $display("FAIL restart_remaining cyc=%0d got=%0d exp=%0d", cyc, bus.remaining, exp_r);
      end
`endif
    end
  endtask

  // N=1, then a new N=1 start in the DONE cycle (11): second finished at 22.
  task automatic test_back_to_back();
    logic exp_b, exp_f;
    cyc = 0;
    bus.seconds_to_count = 16'd1;
    bus.start            = 1'b1;
    for (int i = 0; i < 28; i++) begin
      step();
      bus.start = 1'b0;
      if (cyc == 11) bus.start = 1'b1;
      exp_b = ((cyc >= 1) && (cyc <= 10)) || ((cyc >= 12) && (cyc <= 21));
      exp_f = (cyc == 11) || (cyc == 22);
      assertions++;
      if (bus.busy !== exp_b) begin
        failures++;
        $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_b);
      end
      assertions++;
      if (bus.finished !== exp_f) begin
        failures++;
        $display("FAIL b2b_finished cyc=%0d got=%b exp=%b", cyc, bus.finished, exp_f);
      end
    end
  endtask

  // N=3, reset mid-cycle 15 for two cycles: outputs clear at once, no
  // finished ever; a later N=1 start completes 11 cycles after it.
  task automatic test_async_reset();
    logic exp_b, exp_f;
    int   c0;
    cyc = 0;
    bus.seconds_to_count = 16'd3;
    bus.start            = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      bus.start = 1'b0;
      assertions++;
      if (bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL areset_pre_busy cyc=%0d got=%b exp=1", cyc, bus.busy);
      end
    end
    reset = 1'b1;
    #2;
    assertions++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate_busy got=%b exp=0", bus.busy);
    end
    assertions++;
    if (bus.finished !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate_finished got=%b exp=0", bus.finished);
    end
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      assertions++;
      if ((bus.busy !== 1'b0) || (bus.finished !== 1'b0)) begin
        failures++;
        $display("FAIL areset_quiet cyc=%0d got busy=%b finished=%b exp=0/0", cyc, bus.busy, bus.finished);
      end
    end
    c0 = cyc;
    bus.seconds_to_count = 16'd1;
    bus.start            = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      bus.start = 1'b0;
      exp_b = ((cyc - c0) >= 1) && ((cyc - c0) <= 10);
      exp_f = ((cyc - c0) == 11);
      assertions++;
      if (bus.busy !== exp_b) begin
        failures++;
        $display("FAIL areset_after_busy rel=%0d got=%b exp=%b", cyc - c0, bus.busy, exp_b);
      end
      assertions++;
      if (bus.finished !== exp_f) begin
        failures++;
        $display("FAIL areset_after_finished rel=%0d got=%b exp=%b", cyc - c0, bus.finished, exp_f);
      end
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    cyc        = 0;
    test_reset();
    test_basic();
    test_zero();
    test_enable();
    test_restart();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule : tb_phase_timer

// File: doc/phase_timer.md
# phase_timer

Seconds-resolution phase timer answering the intersection controller's "count N seconds, tell me when done" request. It accepts a start pulse with a 16-bit seconds value and counts on the 10 kHz low-frequency oscillator clock. It returns a single-cycle `finished` pulse when the interval expires. It sits between the general traffic FSM and the lamp drivers' clock domain, replacing ad-hoc counting inside the controller.

## Interface
- `CLK_HZ`, 10000: clock cycles per second (LFOSC rate); must be ≥ 2.
- `SEC_W`, 16: width of the seconds value.
- `clk` in 1: single clock (10 kHz LFOSC).
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: count enable; low freezes the timer without losing state.
- `start` in 1: request pulse; samples `seconds_to_count` on the cycle it is high.
- `seconds_to_count` in SEC_W: interval length in seconds.
- `busy` out 1: high while an interval is being counted.
- `finished` out 1: one-cycle pulse at interval expiry.
- `remaining` out SEC_W: whole seconds left (present only with `PHASE_TIMER_REMAIN_EN`).

## Operation
- States: IDLE, COUNT, DONE. Registers: `presc` ($clog2(CLK_HZ) bits), `sec_cnt` (SEC_W bits).
- IDLE, `start`=1, N=`seconds_to_count`:
  - N=0: go to DONE.
  - N>0: go to COUNT with `sec_cnt`←N and `presc`←0.
- COUNT, `enable`=1: `presc` increments.
  - At `presc`=CLK_HZ-1 it wraps to 0 and `sec_cnt` decrements.
  - A wrap with `sec_cnt`=1 moves to DONE.
- COUNT, `enable`=0: `presc` and `sec_cnt` hold.
- `start` in COUNT: restart. Reload as from IDLE; the aborted interval produces no `finished`.
- DONE: `finished`=1 for exactly this cycle. Next state is IDLE, or the new load if `start`=1 in DONE.
- `enable` is ignored in IDLE and DONE. A start is always accepted.
- `seconds_to_count` is sampled only on `start`. Later changes do not affect a running interval.
- Decrement never underflows. N=2^SEC_W-1 is legal.

## Timing
- Reset values: state IDLE; `busy`, `finished`, `presc`, `sec_cnt` and `remaining` all 0. The async assert clears outputs immediately, mid-interval included; no `finished` follows.
- Outputs are registered state decodes:
  - `busy` = (state==COUNT).
  - `finished` = (state==DONE).
- Start sampled in cycle t with N>0 and `enable` held high:
  - `busy` is high in cycles t+1 … t+N·CLK_HZ.
  - `finished` is high in cycle t+N·CLK_HZ+1.
- N=0: `finished` is high in cycle t+1; `busy` never rises.
- Each disabled COUNT cycle delays `finished` by one cycle.

## Configuration
- `PHASE_TIMER_REMAIN_EN` defined:
  - `remaining` port exists.
  - It equals `sec_cnt` in COUNT and 0 in IDLE/DONE.
  - Intended for countdown displays on pedestrian heads.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `traffic_pkg` holds:
  - `SEC_W`=16.
  - `LFOSC_HZ`=10000.
  - The state enum `phase_timer_state_t` (IDLE, COUNT, DONE).
- Sub-module `sec_tick_gen` holds the prescaler:
  - Inputs: `clk`, `reset`, `clear`, `enable`.
  - Output: one-cycle `tick` at `presc` wrap.
  - The top keeps the FSM and `sec_cnt`.

## Test plan
All scenarios use CLK_HZ=10 for simulation; start is a one-cycle pulse in cycle 0.
- N=3, enable=1 → `busy` high in cycles 1–30; `finished` high only in cycle 31.
- N=0 → `finished` high in cycle 1; `busy` stays 0.
- N=2, enable low in cycles 8–12 → `finished` high in cycle 26; `busy` high in cycles 1–25.
- Restart: N=5, then start with N=1 in cycle 20 → `finished` only in cycle 31; no pulse near cycle 51.
- Reset: N=3, reset asserted in cycle 15 for 2 cycles → `busy`=0 asynchronously, no `finished`. A subsequent start with N=1 completes normally 11 cycles later.
- With `PHASE_TIMER_REMAIN_EN`, N=3 → `remaining` is 3 in cycles 1–10, 2 in cycles 11–20, 1 in cycles 21–30, and 0 from cycle 31.
